// File: rtl/uart_irq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_irq_ctrl_if                                           |
// | Description : Bus bundle between the UART receiver, the MIPS CPU and     |
// |               uart_irq_ctrl. Carries the receive strobe, the interrupt/  |
// |               ack handshake and the LED write path.                      |
// | Signals     : rx_valid, rx_byte               uart -> ctrl               |
// |               int0, uart_read_byte            ctrl -> cpu                |
// |               uart_read_end                   cpu  -> ctrl (level ack)   |
// |               leds_write, leds_write_byte     cpu  -> ctrl               |
// |               leds                            ctrl -> board              |
// | Modports    : slave  = uart_irq_ctrl side                                |
// |               master = uart/cpu side (drives the inputs of the ctrl)     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface uart_irq_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       int0;
  logic [7:0] uart_read_byte;
  logic       uart_read_end;
  logic       leds_write;
  logic [7:0] leds_write_byte;
  logic [7:0] leds;

  modport slave (
    input  rx_valid, rx_byte, uart_read_end, leds_write, leds_write_byte,
    output int0, uart_read_byte, leds
  );

  modport master (
    output rx_valid, rx_byte, uart_read_end, leds_write, leds_write_byte,
    input  int0, uart_read_byte, leds
  );
endinterface
`default_nettype wire

// File: rtl/uart_irq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_irq_ctrl                                              |
// | Description : Queues received UART bytes in a small FIFO and hands them  |
// |               to the CPU one at a time through int0 and the              |
// |               uart_read_end acknowledge. Flags dropped bytes (sticky     |
// |               overrun) and holds the CPU-written LED register.           |
// | Ports       : clk, rst       clock, synchronous active-high reset        |
// |               bus (slave)    rx strobe/byte, int0, uart_read_byte,       |
// |                              uart_read_end, LED write path, leds         |
// |               fifo_level     number of entries held                      |
// |               overrun        sticky: a byte was dropped                  |
// |               ovr_count      dropped-byte count, saturating at 8'hFF     |
// |                              (present only with UART_OVR_CNT_EN)         |
// | Parameters  : FIFO_DEPTH (power of 2, >= 2), LED_RESET                   |
// | Macro       : UART_OVR_CNT_EN enables the ovr_count port and counter     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_irq_ctrl #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] LED_RESET  = 8'h00
) (
  input  wire                              clk,
  input  wire                              rst,
  uart_irq_ctrl_if.slave                   bus,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             overrun
`ifdef UART_OVR_CNT_EN
  ,
  output logic [7:0]                       ovr_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IRQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic               end_q, end_d;
  logic               int0_q, int0_d;
  logic [7:0]         rbyte_q, rbyte_d;
  logic [7:0]         leds_q, leds_d;
  logic               ovr_q, ovr_d;
  logic [7:0]         ovr_cnt_q, ovr_cnt_d;

  logic w_ack_rise;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_drop;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    mem_d     = mem_q;
    end_d     = bus.uart_read_end;
    leds_d    = leds_q;
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;

    w_ack_rise = bus.uart_read_end & ~end_q;
    w_full     = (level_q == LVL_W'(FIFO_DEPTH));
    // Only the IRQ state consumes an ack; edges seen in IDLE/ACK are ignored,
    // so a held-high ack pops exactly once.
    w_pop      = (state_q == S_IRQ) && w_ack_rise && (level_q != '0);
    // A pop on the same edge frees the slot the incoming byte needs.
    w_push     = bus.rx_valid && (!w_full || w_pop);
    w_drop     = bus.rx_valid && w_full && !w_pop;

    if (w_push) begin
      mem_d[wr_ptr_q] = bus.rx_byte;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (w_drop) begin
      ovr_d = 1'b1;
      if (ovr_cnt_q != 8'hFF) begin
        ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE:  if (level_q != '0) state_d = S_IRQ;
      S_IRQ:   if (w_pop)         state_d = S_ACK;
      S_ACK:   if (!bus.uart_read_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    int0_d  = (state_d == S_IRQ);
    rbyte_d = (level_d == '0) ? 8'h00 : mem_d[rd_ptr_d];

    if (bus.leds_write) begin
      leds_d = bus.leds_write_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      end_q     <= 1'b0;
      int0_q    <= 1'b0;
      rbyte_q   <= 8'h00;
      leds_q    <= LED_RESET;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      end_q     <= end_d;
      int0_q    <= int0_d;
      rbyte_q   <= rbyte_d;
      leds_q    <= leds_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  // Storage needs no reset: the level counter decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.int0           = int0_q;
  assign bus.uart_read_byte = rbyte_q;
  assign bus.leds           = leds_q;
  assign fifo_level         = level_q;
  assign overrun            = ovr_q;
`ifdef UART_OVR_CNT_EN
  assign ovr_count          = ovr_cnt_q;
`else
  logic w_unused_ovr_cnt;
  assign w_unused_ovr_cnt = ^ovr_cnt_q;
`endif

endmodule
`default_nettype wire
